host_cmd_framer: RTL

Host-side command master that drives the system's serial command interface at byte level.
- Accepts one command descriptor over a valid/ready handshake.
- Emits the protocol byte sequence to an upstream UART transmitter using a byte valid/ready handshake.
- Collects response bytes from a UART receiver and reports result, or timeout, as a single-cycle pulse.
- Directly upstream of the system's RX_IN path and downstream of its TX_OUT path. The bench and the FPGA host wrapper use it as the command source.

---
 rtl/host_cmd_framer_pkg.sv | 56 +++++
 rtl/host_cmd_framer_rsp_timer.sv | 46 ++++
 rtl/host_cmd_framer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/host_cmd_framer_pkg.sv
// -----------------------------------------------------------------------------
// host_cmd_pkg
// Shared definitions for the host command framer: command type encoding,
// protocol opcode bytes, FSM state encoding, and frame/response length
// helpers.
// -----------------------------------------------------------------------------
package host_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_DONE
    } state_e;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    function automatic logic [7:0] opcode(input cmd_type_e t);
        case (t)
            CMD_RF_WR:  return OPC_RF_WR;
            CMD_RF_RD:  return OPC_RF_RD;
            CMD_ALU_OP: return OPC_ALU_OP;
            default:    return OPC_ALU_NOP;
        endcase
    endfunction

    // Number of bytes on the wire, opcode included.
    function automatic logic [2:0] frame_len(input cmd_type_e t);
        case (t)
            CMD_RF_WR:  return 3'd3;
            CMD_RF_RD:  return 3'd2;
            CMD_ALU_OP: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

    // Number of response bytes expected back.
    function automatic logic [1:0] rsp_len(input cmd_type_e t);
        case (t)
            CMD_RF_WR:  return 2'd0;
            CMD_RF_RD:  return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_framer_rsp_timer.sv
// -----------------------------------------------------------------------------
// rsp_timer
// Idle-cycle counter used while waiting for response bytes.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : clear counter to zero (has priority over en_i)
//   en_i   : count this cycle
//   hit_o  : this enabled cycle is the LIMIT-th consecutive counted cycle
// -----------------------------------------------------------------------------
module rsp_timer #(
    parameter int TO_WD = 16,
    parameter int LIMIT = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [TO_WD-1:0] LAST = TO_WD'(LIMIT - 1);

    logic [TO_WD-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TO_WD'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds the number of idle cycles already elapsed, so the
    // LIMIT-th idle cycle is the one where it reads LIMIT-1.
    assign hit_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/host_cmd_framer.sv
// -----------------------------------------------------------------------------
// host_cmd_framer
// Host-side command master: accepts one command descriptor, serialises it as
// a protocol byte frame to a UART transmitter, collects the response bytes
// from a UART receiver and reports the result (or a timeout) as a pulse.
//   CLK, RST            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : descriptor handshake
//   cmd_type/addr/wdata/op_a/op_b/fun : descriptor fields
//   tx_byte/tx_valid/tx_ready : byte stream to the transmitter
//   rx_byte/rx_valid    : single-cycle byte strobe from the receiver
//   rsp_valid           : one-cycle result strobe
//   rsp_data            : byte0 in low half, byte1 in high half
//   rsp_timeout         : qualifies rsp_valid, response incomplete
//   busy                : high whenever not idle
// -----------------------------------------------------------------------------
module host_cmd_framer
    import host_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_SIZE      = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_WD          = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [ADDR_SIZE-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH-1:0]   cmd_op_a,
    input  logic [DATA_WIDTH-1:0]   cmd_op_b,
    input  logic [3:0]              cmd_fun,
    output logic [DATA_WIDTH-1:0]   tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_byte,
    input  logic                    rx_valid,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_timeout,
    output logic                    busy
);

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic                    rcnt_q, rcnt_d;
    cmd_type_e               type_q, type_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic [3:0]              fun_q, fun_d;
    logic [DATA_WIDTH-1:0]   tx_byte_q, tx_byte_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                    rsp_to_q, rsp_to_d;
    logic                    tmr_hit;

    // Byte at position idx of the frame for the given descriptor.
    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input cmd_type_e             t,
        input logic [1:0]            idx,
        input logic [ADDR_SIZE-1:0]  addr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [3:0]            fun
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (idx)
            2'd0: r = DATA_WIDTH'(opcode(t));
            2'd1: begin
                if (t == CMD_ALU_OP)       r = a;
                else if (t == CMD_ALU_NOP) r = DATA_WIDTH'(fun);
                else                       r = DATA_WIDTH'(addr);
            end
            2'd2: r = (t == CMD_RF_WR) ? wdata : b;
            default: r = DATA_WIDTH'(fun);
        endcase
        return r;
    endfunction

    rsp_timer #(
        .TO_WD (TO_WD),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i ((state_q != ST_WAIT_RSP) || rx_valid),
        .en_i  (state_q == ST_WAIT_RSP),
        .hit_o (tmr_hit)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rcnt_d     = rcnt_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        fun_d      = fun_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        rsp_data_d = rsp_data_q;
        rsp_to_d   = rsp_to_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    type_d     = cmd_type_e'(cmd_type);
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    opa_d      = cmd_op_a;
                    opb_d      = cmd_op_b;
                    fun_d      = cmd_fun;
                    idx_d      = '0;
                    rcnt_d     = 1'b0;
                    rsp_data_d = '0;
                    rsp_to_d   = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = DATA_WIDTH'(opcode(cmd_type_e'(cmd_type)));
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if ({1'b0, idx_q} == frame_len(type_q) - 3'd1) begin
                        tx_valid_d = 1'b0;
                        state_d    = (rsp_len(type_q) != 2'd0) ? ST_WAIT_RSP : ST_DONE;
                    end else begin
                        // Next byte is loaded on the accepting edge: no bubble.
                        idx_d     = idx_q + 2'd1;
                        tx_byte_d = frame_byte(type_q, idx_q + 2'd1, addr_q, wdata_q,
                                               opa_q, opb_q, fun_q);
                    end
                end
            end

            ST_WAIT_RSP: begin
                // A byte arriving on the limit cycle wins over the timeout.
                if (rx_valid) begin
                    if (rcnt_q == 1'b0) rsp_data_d[DATA_WIDTH-1:0]            = rx_byte;
                    else                rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = rx_byte;
                    if ({1'b0, rcnt_q} == rsp_len(type_q) - 2'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        rcnt_d = 1'b1;
                    end
                end else if (tmr_hit) begin
                    rsp_to_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rcnt_q     <= 1'b0;
            type_q     <= CMD_RF_WR;
            addr_q     <= '0;
            wdata_q    <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            fun_q      <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rcnt_q     <= rcnt_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            fun_q      <= fun_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            rsp_data_q <= rsp_data_d;
            rsp_to_q   <= rsp_to_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE) && !RST;
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_timeout = rsp_to_q;
    assign rsp_data    = rsp_data_q;
    assign tx_byte     = tx_byte_q;
    assign tx_valid    = tx_valid_q;

endmodule
